write_burst_ctrl: RTL

//  Sequences the output-pixel write path to SDRAM. Packs the filtered pixel stream into two ping-pong banks of GROUP_LEN pixels.

---
 rtl/wb_ctrl_pkg.sv | 22 ++
 rtl/wb_bank.sv | 24 ++
 rtl/write_burst_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ctrl_pkg.sv
// rtl/wb_ctrl_pkg.sv - shared types and sizing for the write burst controller
package wb_ctrl_pkg;

  localparam int GROUP_LEN = 6;
  localparam int DATA_W    = 24;
  localparam int IDX_W     = $clog2(GROUP_LEN);
  localparam int CNT_W     = $clog2(GROUP_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    RESP,
    DONE
  } wb_state_t;

  typedef enum logic {
    EMPTY,
    FULL
  } bank_state_t;

endpackage

// File: rtl/wb_bank.sv
// rtl/wb_bank.sv - one ping-pong pixel bank, synchronous write / asynchronous read
module wb_bank
  import wb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [GROUP_LEN];

  // Slot storage only; occupancy is tracked by the controller, so no reset is needed
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/write_burst_ctrl.sv
// rtl/write_burst_ctrl.sv - ping-pong pixel packer and Avalon-MM write sequencer (option macro WRITE_BURST_EN)
module write_burst_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0080_0000,
  parameter int                ADDR_STRIDE  = 4,
  parameter int                FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic              pixel_done,
  output logic              pixel_ready,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic [31:0]       master_writedata,
`ifdef WRITE_BURST_EN
  output logic [3:0]        master_burstcount,
`endif
  input  logic              master_waitrequest,
  input  logic              master_writeresponsevalid,
  output logic              group_done,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam int FP_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_LEN - 1);
  localparam logic [FP_W-1:0]  FRAME_END = FP_W'(FRAME_PIXELS);
`ifdef WRITE_BURST_EN
  localparam logic [CNT_W-1:0]  EXP_RESP  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] GROUP_INC = ADDR_W'(GROUP_LEN * ADDR_STRIDE);
`else
  localparam logic [CNT_W-1:0]  EXP_RESP  = CNT_W'(GROUP_LEN);
  localparam logic [ADDR_W-1:0] BEAT_INC  = ADDR_W'(ADDR_STRIDE);
`endif

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  bank_state_t       r_bank_st [2];
  logic              r_fill_sel;
  logic              r_drain_sel;
  logic [IDX_W-1:0]  r_fill_idx;
  logic [IDX_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  r_resp_cnt;
  logic [FP_W-1:0]   r_frame_pix;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow;

  logic              w_start_go;
  logic              w_accept;
  logic              w_fill_last;
  logic              w_beat_acc;
  logic              w_last_beat;
  logic              w_resp_in;
  logic              w_close;
  logic [FP_W-1:0]   w_frame_pix_nxt;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd_data;

  assign w_start_go      = start && (r_state == IDLE);
  assign w_accept        = pixel_done && pixel_ready;
  assign w_fill_last     = w_accept && (r_fill_idx == LAST_IDX);
  assign w_beat_acc      = (r_state == ISSUE) && !master_waitrequest;
  assign w_last_beat     = w_beat_acc && (r_beat_cnt == LAST_IDX);
  assign w_resp_in       = master_writeresponsevalid
                           && ((r_state == ISSUE) || (r_state == RESP))
                           && (r_resp_cnt < EXP_RESP);
  assign w_close         = (r_state == RESP) && (r_resp_cnt == EXP_RESP);
  assign w_frame_pix_nxt = r_frame_pix + FP_W'(GROUP_LEN);
  assign w_rd_data       = r_drain_sel ? w_rd1 : w_rd0;

  wb_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_accept && !r_fill_sel),
    .i_widx  (r_fill_idx),
    .i_wdata (pixel_data),
    .i_ridx  (r_beat_cnt),
    .o_rdata (w_rd0)
  );

  wb_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_accept && r_fill_sel),
    .i_widx  (r_fill_idx),
    .i_wdata (pixel_data),
    .i_ridx  (r_beat_cnt),
    .o_rdata (w_rd1)
  );

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and bus/status outputs, all from registered state
  always_comb begin
    w_state_nxt      = r_state;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = 32'h0;
`ifdef WRITE_BURST_EN
    master_burstcount = 4'd0;
`endif
    busy             = (r_state != IDLE);
    frame_done       = (r_state == DONE);
    group_done       = w_close;
    overflow         = r_overflow;
    pixel_ready      = (r_state != IDLE) && (r_bank_st[r_fill_sel] == EMPTY);
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FILL;
      end
      FILL: begin
        if (r_bank_st[r_drain_sel] == FULL) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        master_write     = 1'b1;
        master_address   = r_addr;
        master_writedata = {8'h00, w_rd_data};
`ifdef WRITE_BURST_EN
        master_burstcount = 4'(GROUP_LEN);
`endif
        if (w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        if (w_close) w_state_nxt = (w_frame_pix_nxt == FRAME_END) ? DONE : FILL;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bank occupancy and ping-pong selectors; a fill and a close land on opposite banks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bank_st[0] <= EMPTY;
      r_bank_st[1] <= EMPTY;
      r_fill_sel   <= 1'b0;
      r_drain_sel  <= 1'b0;
      r_fill_idx   <= '0;
    end else if (w_start_go) begin
      r_bank_st[0] <= EMPTY;
      r_bank_st[1] <= EMPTY;
      r_fill_sel   <= 1'b0;
      r_drain_sel  <= 1'b0;
      r_fill_idx   <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_close && (r_drain_sel == 1'(b))) begin
          r_bank_st[b] <= EMPTY;
        end else if (w_fill_last && (r_fill_sel == 1'(b))) begin
          r_bank_st[b] <= FULL;
        end
      end
      if (w_accept) begin
        if (w_fill_last) begin
          r_fill_idx <= '0;
          r_fill_sel <= ~r_fill_sel;
        end else begin
          r_fill_idx <= r_fill_idx + IDX_W'(1);
        end
      end
      if (w_close) begin
        r_drain_sel <= ~r_drain_sel;
      end
    end
  end

  // Beat, response and frame progress counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_beat_cnt  <= '0;
      r_resp_cnt  <= '0;
      r_frame_pix <= '0;
    end else if (w_start_go) begin
      r_beat_cnt  <= '0;
      r_resp_cnt  <= '0;
      r_frame_pix <= '0;
    end else begin
      if (w_beat_acc) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + IDX_W'(1);
      end
      if (w_close) begin
        r_resp_cnt  <= '0;
        r_frame_pix <= w_frame_pix_nxt;
      end else if (w_resp_in) begin
        r_resp_cnt <= r_resp_cnt + CNT_W'(1);
      end
    end
  end

  // Write address: per accepted beat for single writes, per closed group for bursts
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr <= BASE_ADDR;
    end else if (w_start_go) begin
      r_addr <= BASE_ADDR;
`ifdef WRITE_BURST_EN
    end else if (w_close) begin
      r_addr <= r_addr + GROUP_INC;
`else
    end else if (w_beat_acc) begin
      r_addr <= r_addr + BEAT_INC;
`endif
    end
  end

  // Sticky overflow: a pixel offered while no fill bank was free
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overflow <= 1'b0;
    end else if (w_start_go) begin
      r_overflow <= 1'b0;
    end else if (pixel_done && !pixel_ready) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
